// File: rtl/fir_capture_pkg.sv
// Shared types and helpers for the FIR result capture block.
package fir_capture_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} cap_state_t;

  localparam int unsigned MAX_W = 64;

  // Offset-binary to two's complement: invert the MSB of a w-bit value.
  function automatic logic [MAX_W-1:0] offset_to_signed(input logic [MAX_W-1:0] d,
                                                        input int unsigned    w);
    return d ^ (MAX_W'(1) << (w - 1));
  endfunction

endpackage

// File: rtl/fir_capture_fifo.sv
// Frame FIFO with wrap-bit pointers and a registered head-of-queue read port.
module fir_capture_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic             full,
  output logic             empty,
  output logic             one_left,
  output logic [WIDTH-1:0] rd_data
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rd_data_q;
  logic [AW-1:0]    rd_nxt_idx;

  assign rd_nxt_idx = rd_ptr_q[AW-1:0] + AW'(1);
  assign empty      = (wr_ptr_q == rd_ptr_q);
  assign full       = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign one_left   = ((wr_ptr_q - rd_ptr_q) == PW'(1));
  assign rd_data    = rd_data_q;

  // Head register: bypass the write when the queue is (or is becoming) empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      rd_data_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      if (push && (empty || (pop && one_left))) rd_data_q <= wr_data;
      else if (pop)                             rd_data_q <= mem_q[rd_nxt_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/fir_out_capture.sv
// Decimate, sign-convert, queue and serialise FIR result frames to a valid/ready sink.
// Optional FIR_CAPTURE_DROPCNT_EN adds a saturating drop_cnt output.
module fir_out_capture
  import fir_capture_pkg::*;
#(
  parameter int unsigned N_CH      = 1,
  parameter int unsigned OUT_WIDTH = 32,
  parameter int unsigned OSR       = 1,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned LENGTH    = 24000
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      in_valid,
  input  logic [N_CH*OUT_WIDTH-1:0]                 in_data,
  output logic [OUT_WIDTH-1:0]                      out_data,
  output logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0] out_ch,
  output logic                                      out_last,
  output logic                                      out_valid,
  input  logic                                      out_ready,
  output logic                                      overflow,
  output logic                                      done
`ifdef FIR_CAPTURE_DROPCNT_EN
  , output logic [15:0]                             drop_cnt
`endif
);

  localparam int unsigned FW    = N_CH * OUT_WIDTH;
  localparam int unsigned CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int unsigned PH_W  = (OSR > 1) ? $clog2(OSR) : 1;
  localparam int unsigned CNT_W = (LENGTH > 1) ? $clog2(LENGTH + 1) : 1;

  cap_state_t       state_q, state_d;
  logic [PH_W-1:0]  phase_q, phase_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CH_W-1:0]  ch_q, ch_d;
  logic             overflow_q, overflow_d;
  logic             done_q, done_d;
`ifdef FIR_CAPTURE_DROPCNT_EN
  logic [15:0]      drop_q, drop_d;
`endif

  logic [FW-1:0] conv, rd_data;
  logic fifo_full, fifo_empty, fifo_one_left;
  logic accept, kept, push, pop, xfer;

  always_comb begin
    conv = '0;
    for (int unsigned c = 0; c < N_CH; c++)
      conv[c*OUT_WIDTH +: OUT_WIDTH] =
        OUT_WIDTH'(offset_to_signed(MAX_W'(in_data[c*OUT_WIDTH +: OUT_WIDTH]), OUT_WIDTH));
  end

  fir_capture_fifo #(.DEPTH(DEPTH), .WIDTH(FW)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .pop      (pop),
    .wr_data  (conv),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .one_left (fifo_one_left),
    .rd_data  (rd_data)
  );

  always_comb begin
    out_data = '0;
    for (int unsigned c = 0; c < N_CH; c++)
      if (ch_q == CH_W'(c)) out_data = rd_data[c*OUT_WIDTH +: OUT_WIDTH];
  end

  assign out_valid = ~fifo_empty;
  assign out_ch    = ch_q;
  assign out_last  = out_valid && (ch_q == CH_W'(N_CH - 1));
  assign xfer      = out_valid && out_ready;
  assign pop       = xfer && out_last;
  assign accept    = in_valid && ((state_q == IDLE) || (state_q == RUN));
  assign kept      = accept && (phase_q == '0);
  // A frame may enter a full FIFO only when the head frame leaves on this edge.
  assign push      = kept && (!fifo_full || pop);
  assign overflow  = overflow_q;
  assign done      = done_q;
`ifdef FIR_CAPTURE_DROPCNT_EN
  assign drop_cnt  = drop_q;
`endif

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    cnt_d      = cnt_q;
    ch_d       = ch_q;
    overflow_d = overflow_q;
`ifdef FIR_CAPTURE_DROPCNT_EN
    drop_d     = drop_q;
`endif
    if (accept) phase_d = (phase_q == PH_W'(OSR - 1)) ? '0 : phase_q + PH_W'(1);
    if (xfer)   ch_d    = out_last ? '0 : ch_q + CH_W'(1);
    if (push)   cnt_d   = cnt_q + CNT_W'(1);
    if (kept && !push) begin
      overflow_d = 1'b1;
`ifdef FIR_CAPTURE_DROPCNT_EN
      if (drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
`endif
    end
    case (state_q)
      IDLE:  if (in_valid) state_d = RUN;
      RUN:   ;
      DRAIN: if (fifo_empty || (pop && fifo_one_left)) state_d = DONE;
      DONE:  ;
      default: state_d = IDLE;
    endcase
    if (push && (LENGTH != 0) && (cnt_q == CNT_W'(LENGTH - 1))) state_d = DRAIN;
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      phase_q    <= '0;
      cnt_q      <= '0;
      ch_q       <= '0;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
`ifdef FIR_CAPTURE_DROPCNT_EN
      drop_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      cnt_q      <= cnt_d;
      ch_q       <= ch_d;
      overflow_q <= overflow_d;
      done_q     <= done_d;
`ifdef FIR_CAPTURE_DROPCNT_EN
      drop_q     <= drop_d;
`endif
    end
  end

endmodule
